// File: rtl/tl45_wb_memslave.sv
// -----------------------------------------------------------------------------
// tl45_wb_memslave
//
// Pipelined-Wishbone memory slave with a fixed, parameterised response
// latency. One transaction is outstanding at a time: the slave stalls from
// acceptance until its single ack/err cycle has gone by. Reads return the
// whole stored word; writes merge only the byte lanes selected by i_wb_sel.
// Requests whose word address falls outside the window
// [BASE_WADDR, BASE_WADDR+DEPTH_WORDS) complete with an error and leave the
// memory untouched.
//
// Parameters
//   DEPTH_WORDS  memory depth in 32-bit words (power of two, 16..65536)
//   BASE_WADDR   word address of memory location 0 (aligned to DEPTH_WORDS)
//   WAIT_STATES  extra response cycles beyond the minimum (0..15)
//
// Ports
//   i_clk        system clock, rising-edge
//   i_reset_n    synchronous active-low reset
//   i_wb_cyc     bus cycle active; dropping it aborts a pending request
//   i_wb_stb     request strobe
//   i_wb_we      1 = write, 0 = read
//   i_wb_addr    30-bit word address
//   i_wb_data    write data
//   i_wb_sel     byte enables, bit n covers data[8n+7:8n]
//   o_wb_ack     successful completion, one-cycle pulse
//   o_wb_stall   high while a request is in flight
//   o_wb_err     failed (out-of-range) completion, one-cycle pulse
//   o_wb_data    read data, zero except while o_wb_ack is high on a read
// -----------------------------------------------------------------------------
module tl45_wb_memslave #(
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [29:0] BASE_WADDR  = 30'h0,
   parameter int          WAIT_STATES = 1
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_wb_cyc,
   input  logic        i_wb_stb,
   input  logic        i_wb_we,
   input  logic [29:0] i_wb_addr,
   input  logic [31:0] i_wb_data,
   input  logic [3:0]  i_wb_sel,
   output logic        o_wb_ack,
   output logic        o_wb_stall,
   output logic        o_wb_err,
   output logic [31:0] o_wb_data
);

   localparam int AW = $clog2(DEPTH_WORDS);

   // Counter preload: WAIT_STATES-1 so that the RESPOND cycle lands exactly
   // WAIT_STATES edges after acceptance.
   localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   // Elaboration-time parameter sanity checks.
   if ((DEPTH_WORDS < 16) || (DEPTH_WORDS > 65536) ||
       ((DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0)) begin : g_bad_depth
      $error("tl45_wb_memslave: DEPTH_WORDS must be a power of two in 16..65536");
   end
   if ((BASE_WADDR & 30'(DEPTH_WORDS - 1)) != 30'd0) begin : g_bad_base
      $error("tl45_wb_memslave: BASE_WADDR must be aligned to DEPTH_WORDS");
   end
   if ((WAIT_STATES < 0) || (WAIT_STATES > 15)) begin : g_bad_wait
      $error("tl45_wb_memslave: WAIT_STATES must be in 0..15");
   end

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT    = 2'd1,
      S_RESPOND = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [3:0]  wait_cnt;
   logic [3:0]  wait_cnt_nxt;

   logic        accept;
   logic        addr_in_range;
   logic [AW-1:0] acc_idx;

   // Request captured at acceptance.
   logic          req_we;
   logic          req_in_range;
   logic [AW-1:0] req_idx;
   logic [31:0]   req_data;
   logic [3:0]    req_sel;
   logic [31:0]   rd_data;

   logic        respond_live;
   logic        wr_en;

   // Storage starts out zeroed; reset never clears it.
   logic [31:0] mem [DEPTH_WORDS] = '{default: '0};

   // Because BASE_WADDR is aligned to DEPTH_WORDS, the window test reduces to
   // matching the address bits above the index field.
   assign addr_in_range = (i_wb_addr[29:AW] == BASE_WADDR[29:AW]);
   assign acc_idx       = i_wb_addr[AW-1:0];
   assign accept        = (state == S_IDLE) && i_wb_cyc && i_wb_stb;

   // ---- stage: request decode / next state --------------------------------
   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      case (state)
         S_IDLE: begin
            if (accept) begin
               if (WAIT_STATES == 0) begin
                  state_nxt = S_RESPOND;
               end else begin
                  state_nxt    = S_WAIT;
                  wait_cnt_nxt = WAIT_LOAD;
               end
            end
         end
         S_WAIT: begin
            if (!i_wb_cyc) begin
               // Master gave up: drop the request, nothing is written.
               state_nxt    = S_IDLE;
               wait_cnt_nxt = 4'd0;
            end else if (wait_cnt == 4'd0) begin
               state_nxt = S_RESPOND;
            end else begin
               wait_cnt_nxt = wait_cnt - 4'd1;
            end
         end
         S_RESPOND: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt    = S_IDLE;
            wait_cnt_nxt = 4'd0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state    <= S_IDLE;
         wait_cnt <= 4'd0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
      end
   end

   always_ff @(posedge i_clk) begin
      if (accept) begin
         req_we       <= i_wb_we;
         req_in_range <= addr_in_range;
         req_idx      <= acc_idx;
         req_data     <= i_wb_data;
         req_sel      <= i_wb_sel;
      end
   end

   // ---- stage: response ---------------------------------------------------
   // The response is qualified by cyc and reset in the RESPOND cycle itself,
   // so an abort or reset arriving then suppresses both the handshake and the
   // write that would otherwise land on the closing edge.
   assign respond_live = (state == S_RESPOND) && i_wb_cyc && i_reset_n;
   assign wr_en        = respond_live && req_in_range && req_we;

   // The read port samples at the acceptance edge; writes land only on a
   // RESPOND edge, which can never coincide with an acceptance, so the
   // captured word is always current when it is returned.
   always_ff @(posedge i_clk) begin
      if (accept) begin
         rd_data <= mem[acc_idx];
      end
      for (int b = 0; b < 4; b++) begin
         if (wr_en && req_sel[b]) begin
            mem[req_idx][8*b +: 8] <= req_data[8*b +: 8];
         end
      end
   end

   assign o_wb_stall = (state != S_IDLE);
   assign o_wb_ack   = respond_live && req_in_range;
   assign o_wb_err   = respond_live && !req_in_range;
   assign o_wb_data  = (respond_live && req_in_range && !req_we) ? rd_data : 32'd0;

endmodule

// File: tb/tb_tl45_wb_memslave.sv
// -----------------------------------------------------------------------------
// tb_tl45_wb_memslave
//
// Three slaves share one set of bus inputs:
//   dut_a  WAIT_STATES=1, DEPTH 1024, base 0
//   dut_b  WAIT_STATES=3, DEPTH 16,   base 0x100
//   dut_c  WAIT_STATES=0, DEPTH 1024, base 0
// Each scenario looks only at the slave it targets and uses addresses that
// keep the other slaves' side effects out of its way.
// Inputs are driven at the falling edge; outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_tl45_wb_memslave;

   logic        clk;
   logic        rst_n;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [29:0] addr;
   logic [31:0] wdata;
   logic [3:0]  bsel;

   logic        a_ack, a_stall, a_err;
   logic [31:0] a_data;
   logic        b_ack, b_stall, b_err;
   logic [31:0] b_data;
   logic        c_ack, c_stall, c_err;
   logic [31:0] c_data;

   int checks   = 0;
   int failures = 0;

   // Results of the last xfer()
   logic        r_ack;
   logic        r_err;
   logic [31:0] r_data;
   int          r_lat;

   tl45_wb_memslave #(.DEPTH_WORDS(1024), .BASE_WADDR(30'h0), .WAIT_STATES(1)) dut_a (
      .i_clk(clk), .i_reset_n(rst_n), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
      .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_sel(bsel),
      .o_wb_ack(a_ack), .o_wb_stall(a_stall), .o_wb_err(a_err), .o_wb_data(a_data));

   tl45_wb_memslave #(.DEPTH_WORDS(16), .BASE_WADDR(30'h100), .WAIT_STATES(3)) dut_b (
      .i_clk(clk), .i_reset_n(rst_n), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
      .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_sel(bsel),
      .o_wb_ack(b_ack), .o_wb_stall(b_stall), .o_wb_err(b_err), .o_wb_data(b_data));

   tl45_wb_memslave #(.DEPTH_WORDS(1024), .BASE_WADDR(30'h0), .WAIT_STATES(0)) dut_c (
      .i_clk(clk), .i_reset_n(rst_n), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
      .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_sel(bsel),
      .o_wb_ack(c_ack), .o_wb_stall(c_stall), .o_wb_err(c_err), .o_wb_data(c_data));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // which: 0 = dut_c, 1 = dut_a, 3 = dut_b
   function automatic logic f_ack(input int which);
      case (which)
         0:       return c_ack;
         1:       return a_ack;
         default: return b_ack;
      endcase
   endfunction

   function automatic logic f_err(input int which);
      case (which)
         0:       return c_err;
         1:       return a_err;
         default: return b_err;
      endcase
   endfunction

   function automatic logic [31:0] f_data(input int which);
      case (which)
         0:       return c_data;
         1:       return a_data;
         default: return b_data;
      endcase
   endfunction

   // One complete transaction aimed at the chosen slave. Latency counts the
   // cycles after the accepting edge: 1 means the cycle right after it.
   // Gives up after 40 cycles, leaving r_lat=0 and no ack/err.
   task automatic xfer(input int which, input logic w, input logic [29:0] a,
                       input logic [31:0] d, input logic [3:0] s);
      logic done;
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdata = d; bsel = s;
      @(negedge clk);
      stb = 1'b0;
      done = 1'b0;
      r_ack = 1'b0; r_err = 1'b0; r_data = 32'd0; r_lat = 0;
      for (int i = 1; i <= 40 && !done; i++) begin
         #1;
         if (f_ack(which) || f_err(which)) begin
            done   = 1'b1;
            r_lat  = i;
            r_ack  = f_ack(which);
            r_err  = f_err(which);
            r_data = f_data(which);
         end else begin
            @(negedge clk);
         end
      end
      @(negedge clk);
      cyc = 1'b0; we = 1'b0; bsel = 4'h0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (a_ack !== 1'b0)    begin failures++; $display("FAIL reset_a_ack got=%b exp=0", a_ack); end
      checks++; if (a_err !== 1'b0)    begin failures++; $display("FAIL reset_a_err got=%b exp=0", a_err); end
      checks++; if (a_stall !== 1'b0)  begin failures++; $display("FAIL reset_a_stall got=%b exp=0", a_stall); end
      checks++; if (a_data !== 32'd0)  begin failures++; $display("FAIL reset_a_data got=%h exp=0", a_data); end
      checks++; if (b_stall !== 1'b0)  begin failures++; $display("FAIL reset_b_stall got=%b exp=0", b_stall); end
      checks++; if (c_stall !== 1'b0)  begin failures++; $display("FAIL reset_c_stall got=%b exp=0", c_stall); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_initial_zero();
      xfer(1, 1'b0, 30'h20, 32'd0, 4'hF);
      checks++; if (r_ack !== 1'b1)     begin failures++; $display("FAIL init_read_ack got=%b exp=1", r_ack); end
      checks++; if (r_data !== 32'd0)   begin failures++; $display("FAIL init_read_data got=%h exp=0", r_data); end
   endtask

   task automatic test_write_read();
      // Cycle-by-cycle walk of a WAIT_STATES=1 write.
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 30'h10; wdata = 32'hDEADBEEF; bsel = 4'hF;
      #1;
      checks++; if (a_stall !== 1'b0) begin failures++; $display("FAIL ws1_stall_idle got=%b exp=0", a_stall); end
      @(negedge clk);
      stb = 1'b0;
      #1;
      checks++; if (a_stall !== 1'b1) begin failures++; $display("FAIL ws1_stall_wait got=%b exp=1", a_stall); end
      checks++; if (a_ack !== 1'b0)   begin failures++; $display("FAIL ws1_ack_wait got=%b exp=0", a_ack); end
      @(negedge clk);
      #1;
      checks++; if (a_stall !== 1'b1) begin failures++; $display("FAIL ws1_stall_resp got=%b exp=1", a_stall); end
      checks++; if (a_ack !== 1'b1)   begin failures++; $display("FAIL ws1_ack_resp got=%b exp=1", a_ack); end
      checks++; if (a_err !== 1'b0)   begin failures++; $display("FAIL ws1_err_resp got=%b exp=0", a_err); end
      checks++; if (a_data !== 32'd0) begin failures++; $display("FAIL ws1_wr_data got=%h exp=0", a_data); end
      @(negedge clk);
      #1;
      checks++; if (a_stall !== 1'b0) begin failures++; $display("FAIL ws1_stall_after got=%b exp=0", a_stall); end
      checks++; if (a_ack !== 1'b0)   begin failures++; $display("FAIL ws1_ack_after got=%b exp=0", a_ack); end
      cyc = 1'b0; we = 1'b0;

      xfer(1, 1'b0, 30'h10, 32'd0, 4'hF);
      checks++; if (r_ack !== 1'b1)          begin failures++; $display("FAIL rd10_ack got=%b exp=1", r_ack); end
      checks++; if (r_data !== 32'hDEADBEEF) begin failures++; $display("FAIL rd10_data got=%h exp=deadbeef", r_data); end
      checks++; if (r_lat != 2)              begin failures++; $display("FAIL rd10_latency got=%0d exp=2", r_lat); end
   endtask

   task automatic test_byte_write();
      xfer(1, 1'b1, 30'h11, 32'h11223344, 4'hF);
      xfer(1, 1'b1, 30'h11, 32'h0000AB00, 4'b0010);
      checks++; if (r_ack !== 1'b1) begin failures++; $display("FAIL bytewr_ack got=%b exp=1", r_ack); end
      // Read with no lanes selected still returns the full word.
      xfer(1, 1'b0, 30'h11, 32'd0, 4'h0);
      checks++; if (r_data !== 32'h1122AB44) begin failures++; $display("FAIL bytewr_data got=%h exp=1122ab44", r_data); end
      // Write with no lanes selected acknowledges but changes nothing.
      xfer(1, 1'b1, 30'h11, 32'hFFFFFFFF, 4'h0);
      checks++; if (r_ack !== 1'b1) begin failures++; $display("FAIL sel0_ack got=%b exp=1", r_ack); end
      xfer(1, 1'b0, 30'h11, 32'd0, 4'hF);
      checks++; if (r_data !== 32'h1122AB44) begin failures++; $display("FAIL sel0_data got=%h exp=1122ab44", r_data); end
      // Upper and lowest lanes together.
      xfer(1, 1'b1, 30'h11, 32'hEE0000DD, 4'b1001);
      xfer(1, 1'b0, 30'h11, 32'd0, 4'hF);
      checks++; if (r_data !== 32'hEE22ABDD) begin failures++; $display("FAIL sel9_data got=%h exp=ee22abdd", r_data); end
   endtask

   task automatic test_out_of_range();
      xfer(1, 1'b1, 30'h0, 32'hCAFEF00D, 4'hF);
      // 0x400 aliases index 0 if the window test were missing.
      xfer(1, 1'b1, 30'h400, 32'h12345678, 4'hF);
      checks++; if (r_err !== 1'b1 || r_ack !== 1'b0) begin failures++; $display("FAIL oor_wr_err got=%b/%b exp=1/0", r_err, r_ack); end
      xfer(1, 1'b0, 30'h400, 32'd0, 4'hF);
      checks++; if (r_err !== 1'b1) begin failures++; $display("FAIL oor_rd_err got=%b exp=1", r_err); end
      checks++; if (r_ack !== 1'b0) begin failures++; $display("FAIL oor_rd_ack got=%b exp=0", r_ack); end
      checks++; if (r_data !== 32'd0) begin failures++; $display("FAIL oor_rd_data got=%h exp=0", r_data); end
      xfer(1, 1'b0, 30'h0, 32'd0, 4'hF);
      checks++; if (r_data !== 32'hCAFEF00D) begin failures++; $display("FAIL oor_mem_kept got=%h exp=cafef00d", r_data); end
      // Window with non-zero base: 0xFF and 0x110 sit just outside, 0x10F inside.
      xfer(3, 1'b0, 30'hFF, 32'd0, 4'hF);
      checks++; if (r_err !== 1'b1) begin failures++; $display("FAIL b_below_err got=%b exp=1", r_err); end
      xfer(3, 1'b0, 30'h110, 32'd0, 4'hF);
      checks++; if (r_err !== 1'b1) begin failures++; $display("FAIL b_above_err got=%b exp=1", r_err); end
      xfer(3, 1'b1, 30'h10F, 32'h0BADF00D, 4'hF);
      checks++; if (r_ack !== 1'b1) begin failures++; $display("FAIL b_top_wr_ack got=%b exp=1", r_ack); end
      checks++; if (r_lat != 4)     begin failures++; $display("FAIL b_latency got=%0d exp=4", r_lat); end
      xfer(3, 1'b0, 30'h10F, 32'd0, 4'hF);
      checks++; if (r_data !== 32'h0BADF00D) begin failures++; $display("FAIL b_top_rd_data got=%h exp=0badf00d", r_data); end
   endtask

   task automatic test_abort();
      logic quiet;
      xfer(3, 1'b1, 30'h105, 32'h00000077, 4'hF);
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 30'h105; wdata = 32'h00000055; bsel = 4'hF;
      @(negedge clk);
      cyc = 1'b0; stb = 1'b0;
      #1;
      checks++; if (b_ack !== 1'b0 || b_err !== 1'b0) begin failures++; $display("FAIL abort_resp got=%b/%b exp=0/0", b_ack, b_err); end
      @(negedge clk);
      #1;
      checks++; if (b_stall !== 1'b0) begin failures++; $display("FAIL abort_stall got=%b exp=0", b_stall); end
      quiet = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         #1;
         if (b_ack !== 1'b0 || b_err !== 1'b0) quiet = 1'b0;
      end
      checks++; if (quiet !== 1'b1) begin failures++; $display("FAIL abort_late_resp got=%b exp=1", quiet); end
      we = 1'b0;
      xfer(3, 1'b0, 30'h105, 32'd0, 4'hF);
      checks++; if (r_data !== 32'h00000077) begin failures++; $display("FAIL abort_mem_kept got=%h exp=77", r_data); end
   endtask

   task automatic test_reset_mid();
      logic quiet;
      xfer(3, 1'b1, 30'h106, 32'h00000099, 4'hF);
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 30'h106; wdata = 32'h000000AA; bsel = 4'hF;
      @(negedge clk);
      stb = 1'b0;
      #1;
      checks++; if (b_stall !== 1'b1) begin failures++; $display("FAIL rstmid_in_wait got=%b exp=1", b_stall); end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++; if (b_ack !== 1'b0)   begin failures++; $display("FAIL rstmid_ack got=%b exp=0", b_ack); end
      checks++; if (b_err !== 1'b0)   begin failures++; $display("FAIL rstmid_err got=%b exp=0", b_err); end
      checks++; if (b_stall !== 1'b0) begin failures++; $display("FAIL rstmid_stall got=%b exp=0", b_stall); end
      checks++; if (b_data !== 32'd0) begin failures++; $display("FAIL rstmid_data got=%h exp=0", b_data); end
      quiet = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         #1;
         if (b_ack !== 1'b0 || b_err !== 1'b0) quiet = 1'b0;
      end
      checks++; if (quiet !== 1'b1) begin failures++; $display("FAIL rstmid_late_resp got=%b exp=1", quiet); end
      cyc = 1'b0; we = 1'b0;
      xfer(3, 1'b0, 30'h106, 32'd0, 4'hF);
      checks++; if (r_data !== 32'h00000099) begin failures++; $display("FAIL rstmid_mem_kept got=%h exp=99", r_data); end
   endtask

   task automatic test_back_to_back();
      int          nack;
      logic        exp_b;
      logic [31:0] exp_d;
      for (int k = 0; k < 4; k++) begin
         xfer(0, 1'b1, 30'h30 + 30'(k), 32'hC0DE0000 + 32'(k), 4'hF);
      end
      checks++; if (r_lat != 1) begin failures++; $display("FAIL ws0_latency got=%0d exp=1", r_lat); end
      nack = 0;
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 30'h30; bsel = 4'hF;
      for (int i = 0; i < 8; i++) begin
         #1;
         exp_b = ((i % 2) == 1);
         checks++; if (c_stall !== exp_b) begin failures++; $display("FAIL b2b_stall cyc=%0d got=%b exp=%b", i, c_stall, exp_b); end
         checks++; if (c_ack !== exp_b)   begin failures++; $display("FAIL b2b_ack cyc=%0d got=%b exp=%b", i, c_ack, exp_b); end
         if (c_ack === 1'b1) begin
            exp_d = 32'hC0DE0000 + 32'(nack);
            checks++; if (c_data !== exp_d) begin failures++; $display("FAIL b2b_data cyc=%0d got=%h exp=%h", i, c_data, exp_d); end
            nack++;
            addr = 30'h30 + 30'(nack);
         end
         @(negedge clk);
      end
      stb = 1'b0; cyc = 1'b0;
      checks++; if (nack != 4) begin failures++; $display("FAIL b2b_count got=%0d exp=4", nack); end
   endtask

   initial begin
      rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
      addr = 30'd0; wdata = 32'd0; bsel = 4'h0;
      test_reset();
      test_initial_zero();
      test_write_read();
      test_byte_write();
      test_out_of_range();
      test_abort();
      test_reset_mid();
      test_back_to_back();
      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tl45_wb_memslave.md
TL45_WB_MEMSLAVE -- requirements
Module: tl45_wb_memslave

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: memory depth in 32-bit words; SHALL be a power of two, 16..65536.
REQ-002 Parameter BASE_WADDR, default 30'h0: word address of memory location 0; SHALL be aligned to DEPTH_WORDS.
REQ-003 Parameter WAIT_STATES, default 1: extra response cycles, 0..15.
REQ-004 i_clk  input  1  system clock; all logic on rising edge.
REQ-005 i_reset_n  input  1  synchronous active-low reset.
REQ-006 i_wb_cyc  input  1  bus cycle active.
REQ-007 i_wb_stb  input  1  request strobe.
REQ-008 i_wb_we  input  1  1 = write, 0 = read.
REQ-009 i_wb_addr  input  30  word address.
REQ-010 i_wb_data  input  32  write data.
REQ-011 i_wb_sel  input  4  byte enables; bit n covers data[8n+7:8n].
REQ-012 o_wb_ack  output  1  successful completion, one-cycle pulse.
REQ-013 o_wb_stall  output  1  request not accepted this cycle.
REQ-014 o_wb_err  output  1  failed completion, one-cycle pulse.
REQ-015 o_wb_data  output  32  read data; valid only while o_wb_ack = 1.

Function
REQ-016 Acceptance SHALL occur on a rising edge where i_wb_cyc & i_wb_stb & !o_wb_stall; address, we, data and sel SHALL be latched at acceptance.
REQ-017 States SHALL be IDLE, WAIT, RESPOND; only one transaction outstanding.
REQ-018 o_wb_stall SHALL be 1 exactly when state != IDLE.
REQ-019 IDLE -> WAIT on acceptance when WAIT_STATES > 0, loading wait counter with WAIT_STATES-1; IDLE -> RESPOND on acceptance when WAIT_STATES = 0.
REQ-020 WAIT SHALL decrement the counter each cycle and go to RESPOND the cycle after the counter reads 0.
REQ-021 RESPOND SHALL assert exactly one of o_wb_ack/o_wb_err for that single cycle, then go to IDLE; a request is acceptable again the cycle after RESPOND.
REQ-022 Latency: request accepted at edge N SHALL be answered in the cycle after edge N+WAIT_STATES (WAIT_STATES=0: response in the cycle immediately after acceptance).
REQ-023 In range iff BASE_WADDR <= addr < BASE_WADDR+DEPTH_WORDS; index = addr - BASE_WADDR, log2(DEPTH_WORDS) bits.
REQ-024 Out-of-range request SHALL complete with o_wb_err=1, o_wb_ack=0, o_wb_data=0, no memory change.
REQ-025 In-range read SHALL complete with o_wb_ack=1 and o_wb_data = full stored word, regardless of sel.
REQ-026 In-range write SHALL update only bytes with sel bit set, on the RESPOND edge; sel=4'b0000 SHALL ack with no change; o_wb_data=0 on write ack.
REQ-027 o_wb_data SHALL be 0 whenever o_wb_ack = 0.
REQ-028 If i_wb_cyc = 0 during WAIT or RESPOND, SHALL abort to IDLE next edge: no ack/err, pending write discarded.
REQ-029 i_wb_stb while o_wb_stall = 1 SHALL be ignored (not queued).
REQ-030 o_wb_ack and o_wb_err SHALL never be 1 simultaneously and SHALL never be 1 while i_wb_cyc was 0 in the prior cycle.

Reset
REQ-031 With i_reset_n = 0 at an edge: state -> IDLE, counter -> 0, o_wb_ack=0, o_wb_err=0, o_wb_data=0, o_wb_stall=0 from the next cycle.
REQ-032 Reset mid-transaction SHALL discard it with no ack/err and no write; memory contents SHALL NOT be cleared by reset.
REQ-033 Memory initial contents SHALL be zero at configuration.

Verification
REQ-034 WAIT_STATES=1: write 0xDEADBEEF to addr 0x10, sel=4'hF -> stall 1 for 2 cycles, ack 2 cycles after accept; then read 0x10 -> ack, data 0xDEADBEEF.
REQ-035 Byte write sel=4'b0010, data 0x0000AB00 over word 0x11223344 -> read returns 0x1122AB44.
REQ-036 Read addr BASE_WADDR+DEPTH_WORDS -> o_wb_err=1 one cycle, ack=0, data=0; memory unchanged.
REQ-037 WAIT_STATES=3: write 0x55 accepted, cyc dropped 1 cycle later -> no ack/err, stall 0 next cycle, later read returns old value.
REQ-038 Reset (i_reset_n=0) during WAIT of a write -> no ack, all outputs 0 after reset, written location retains prior contents.
REQ-039 WAIT_STATES=0 back-to-back reads with stb held -> one ack every 2 cycles, stall alternates 0/1, no request lost or duplicated.
